// File: rtl/gpio_debounce.sv
// gpio_debounce: conditions raw switch/button pads for the system GPI bus.
//   Each bit passes through a 2-flop synchroniser and a debounce filter
//   driven by one shared prescaler. A registered rise/fall pulse marks
//   every accepted change.
// Ports:
//   clk_sys_i  system clock
//   rst_sys_i  asynchronous active-high reset
//   gp_raw_i   [Width]  raw asynchronous pad inputs
//   gp_o       [Width]  debounced level
//   rise_o     [Width]  one-cycle pulse on 0->1 of gp_o
//   fall_o     [Width]  one-cycle pulse on 1->0 of gp_o
//   tick_o     prescaler tick, exported for visibility
module gpio_debounce #(
  parameter int               Width       = 8,
  parameter int               TickCycles  = 50000,
  parameter int               StableTicks = 10,
  parameter logic [Width-1:0] ResetValue  = '0,
  parameter bit               Bypass      = 1'b0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] gp_raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             tick_o
);

  localparam int PW = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam int CW = $clog2(StableTicks + 1);
  localparam logic [PW-1:0] PreLast = PW'(TickCycles - 1);
  localparam logic [CW-1:0] CntLast = CW'(StableTicks - 1);

  logic [Width-1:0] r_sync_p0;
  logic [Width-1:0] r_sync_p1;
  logic [PW-1:0]    r_pre;
  logic [PW-1:0]    w_pre_nxt;
  logic             r_tick;
  logic [Width-1:0] r_gp;
  logic [Width-1:0] r_rise;
  logic [Width-1:0] r_fall;
  logic [CW-1:0]    r_cnt     [Width];
  logic [CW-1:0]    w_cnt_nxt [Width];
  logic [Width-1:0] w_gp_nxt;

  // ---- stage p0/p1: two-flop synchroniser, nothing else on these flops
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_sync_p0 <= ResetValue;
      r_sync_p1 <= ResetValue;
    end else begin
      r_sync_p0 <= gp_raw_i;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // ---- prescaler: tick is registered off the next count so that it is
  // high exactly while the count sits at TickCycles-1 and low in reset
  always_comb begin
    w_pre_nxt = (r_pre == PreLast) ? '0 : r_pre + PW'(1);
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= w_pre_nxt;
      r_tick <= (w_pre_nxt == PreLast);
    end
  end

  // ---- filter decision: a matching input clears its count at once, so a
  // bounce back to the old level restarts the window from zero
  always_comb begin
    w_gp_nxt = r_gp;
    for (int i = 0; i < Width; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (Bypass) begin
        w_gp_nxt[i]  = r_sync_p1[i];
        w_cnt_nxt[i] = '0;
      end else if (r_sync_p1[i] == r_gp[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_tick && (r_cnt[i] == CntLast)) begin
        w_gp_nxt[i]  = r_sync_p1[i];
        w_cnt_nxt[i] = '0;
      end else if (r_tick) begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // ---- stage p2: debounced level and edge pulses, pulses computed from
  // the next level so they coincide with the first cycle of the new value
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_gp   <= ResetValue;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < Width; i++) r_cnt[i] <= '0;
    end else begin
      r_gp   <= w_gp_nxt;
      r_rise <= w_gp_nxt & ~r_gp;
      r_fall <= ~w_gp_nxt & r_gp;
      for (int i = 0; i < Width; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign gp_o   = r_gp;
  assign rise_o = r_rise;
  assign fall_o = r_fall;
  assign tick_o = r_tick;

endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: randomized bench for gpio_debounce with a behavioural
// reference. Three instances share the clock and reset: the main filter
// (TickCycles=4, StableTicks=3), a ResetValue=0xFF instance held at 0xFF,
// and a Bypass instance fed the same raw bus as the main one.
module tb_gpio_debounce;
  localparam int TC = 4;
  localparam int ST = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw;
  logic [7:0] raw_rv;
  logic [7:0] gp_o, rise_o, fall_o;
  logic       tick_o;
  logic [7:0] gp_rv, rise_rv, fall_rv;
  logic       tick_rv;
  logic [7:0] gp_bp, rise_bp, fall_bp;
  logic       tick_bp;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  logic [7:0] hist[$];
  logic [7:0] m_gp, m_rise, m_fall;
  logic [7:0] m_bp_gp, m_bp_rise, m_bp_fall;
  logic       m_tick;
  int         m_ticks[8];
  int         m_e;
  logic [7:0] cur;

  always #5 clk = ~clk;

  gpio_debounce #(.Width(8), .TickCycles(TC), .StableTicks(ST),
                  .ResetValue(8'h00), .Bypass(1'b0)) dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .gp_raw_i(raw),
    .gp_o(gp_o), .rise_o(rise_o), .fall_o(fall_o), .tick_o(tick_o));

  gpio_debounce #(.Width(8), .TickCycles(TC), .StableTicks(ST),
                  .ResetValue(8'hFF), .Bypass(1'b0)) dut_rv (
    .clk_sys_i(clk), .rst_sys_i(rst), .gp_raw_i(raw_rv),
    .gp_o(gp_rv), .rise_o(rise_rv), .fall_o(fall_rv), .tick_o(tick_rv));

  gpio_debounce #(.Width(8), .TickCycles(TC), .StableTicks(ST),
                  .ResetValue(8'h00), .Bypass(1'b1)) dut_bp (
    .clk_sys_i(clk), .rst_sys_i(rst), .gp_raw_i(raw),
    .gp_o(gp_bp), .rise_o(rise_bp), .fall_o(fall_bp), .tick_o(tick_bp));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(8'h00);
    hist.push_back(8'h00);
    m_gp = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_tick = 1'b0;
    m_bp_gp = 8'h00; m_bp_rise = 8'h00; m_bp_fall = 8'h00;
    for (int i = 0; i < 8; i++) m_ticks[i] = 0;
    m_e = 0;
  endtask

  // One clock edge of the reference: a bit is accepted on the ST-th tick of
  // an uninterrupted difference between the synchronised input and gp.
  task automatic model_edge(input logic [7:0] r);
    logic [7:0] s;
    logic [7:0] ng;
    logic [7:0] nb;
    logic       tick_now;
    s        = hist[hist.size()-2];
    tick_now = ((m_e % TC) == TC - 1);
    ng       = m_gp;
    for (int i = 0; i < 8; i++) begin
      if (s[i] == m_gp[i]) m_ticks[i] = 0;
      else if (tick_now) begin
        m_ticks[i]++;
        if (m_ticks[i] == ST) begin
          ng[i] = s[i];
          m_ticks[i] = 0;
        end
      end
    end
    m_rise = ng & ~m_gp;
    m_fall = ~ng & m_gp;
    m_gp   = ng;
    hist.push_back(r);
    if (hist.size() > 4) void'(hist.pop_front());
    nb        = hist[hist.size()-3];
    m_bp_rise = nb & ~m_bp_gp;
    m_bp_fall = ~nb & m_bp_gp;
    m_bp_gp   = nb;
    m_e++;
    m_tick = ((m_e % TC) == TC - 1);
  endtask

  task automatic clk_step(input logic [7:0] r);
    raw = r;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(r);
    #1;
    chk("main", {gp_o, rise_o, fall_o, tick_o}, {m_gp, m_rise, m_fall, m_tick});
    chk("bypass", {gp_bp, rise_bp, fall_bp, tick_bp},
        {m_bp_gp, m_bp_rise, m_bp_fall, m_tick});
    chk("rv_hold", {gp_rv, rise_rv, fall_rv, tick_rv}, {8'hFF, 8'h00, 8'h00, m_tick});
  endtask

  task automatic wait_gp(input int b, input logic v, input logic [7:0] r, output int n);
    n = 0;
    do begin
      clk_step(r);
      n++;
    end while (gp_o[b] !== v && n < 40);
  endtask

  task automatic idle_phase();
    repeat ($urandom_range(0, 7)) clk_step(cur);
  endtask

  initial begin
    int n;
    int tcnt;
    int t;
    logic [7:0] pulses;

    rst = 1'b1; raw = 8'h00; raw_rv = 8'hFF; cur = 8'h00;
    model_reset();
    repeat (3) clk_step(cur);
    chk("reset_state", {gp_o, rise_o, fall_o, tick_o}, 25'd0);
    rst = 1'b0;

    // quiet input: no pulses, tick every 4th cycle
    tcnt = 0; pulses = 8'h00;
    repeat (100) begin
      clk_step(cur);
      tcnt += int'(tick_o);
      pulses |= rise_o | fall_o;
    end
    chk("tick_count", tcnt, 25);
    chk("quiet_pulses", pulses, 8'h00);

    // single step up and down on bit 0
    idle_phase();
    cur = 8'h01;
    wait_gp(0, 1'b1, cur, n);
    chk("rise0_lat", (n >= 11 && n <= 14), 1);
    chk("rise0_pulse", rise_o, 8'h01);
    repeat (5) clk_step(cur);
    idle_phase();
    cur = 8'h00;
    wait_gp(0, 1'b0, cur, n);
    chk("fall0_lat", (n >= 11 && n <= 14), 1);
    chk("fall0_pulse", fall_o, 8'h01);

    // bounce on bit 1, then hold high
    idle_phase();
    for (int k = 0; k < 8; k++) begin
      cur[1] = ~cur[1];
      repeat (5) begin
        clk_step(cur);
        chk("bounce_hold", gp_o[1], 1'b0);
      end
    end
    cur[1] = 1'b1;
    wait_gp(1, 1'b1, cur, n);
    chk("bounce_lat", (n >= 11 && n <= 14), 1);
    chk("bounce_pulse", rise_o, 8'h02);
    cur = 8'h00;
    wait_gp(1, 1'b0, cur, n);
    repeat (3) clk_step(cur);

    // 6-cycle glitch on bit 2, then a fresh full window must be needed
    idle_phase();
    cur = 8'h04;
    repeat (6) clk_step(cur);
    cur = 8'h00;
    repeat (20) clk_step(cur);
    chk("glitch_gp", gp_o, 8'h00);
    cur = 8'h04;
    wait_gp(2, 1'b1, cur, n);
    chk("post_glitch_lat", (n >= 11 && n <= 14), 1);
    cur = 8'h00;
    wait_gp(2, 1'b0, cur, n);
    repeat (3) clk_step(cur);

    // all bits together
    idle_phase();
    cur = 8'hFF;
    wait_gp(0, 1'b1, cur, n);
    chk("all_rise", rise_o, 8'hFF);
    chk("all_gp", gp_o, 8'hFF);
    cur = 8'hA5;
    wait_gp(1, 1'b0, cur, n);
    chk("mix_fall", fall_o, 8'h5A);
    chk("mix_gp", gp_o, 8'hA5);

    // random segments, reference checked every cycle
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 1) == 1) cur = cur ^ (8'h01 << $urandom_range(0, 7));
      else                           cur = 8'($urandom);
      repeat ($urandom_range(1, 24)) clk_step(cur);
    end

    // reset in the middle of a window
    cur = 8'h00;
    repeat (20) clk_step(cur);
    cur = 8'h08;
    t = 0;
    while (t < 2) begin
      clk_step(cur);
      if (m_tick) t++;
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst", {gp_o, rise_o, fall_o, tick_o}, 25'd0);
    repeat (3) clk_step(cur);
    rst = 1'b0;
    wait_gp(3, 1'b1, cur, n);
    chk("rst_window_lat", n, 12);
    chk("rst_window_pulse", rise_o, 8'h08);
    repeat (10) clk_step(cur);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
